// File: rtl/pulse_train_driver.sv
// Initiator sequencer for the S/X/g handshake: one S strobe, len+1 X pulses, then a bounded wait for g.
// Define PULSE_GAP_EN to insert a gap cycle (X=0) between consecutive X pulses.
module pulse_train_driver #(
  parameter int CNT_W = 4,
  parameter int TMO   = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             go,
  input  logic [CNT_W-1:0] len,
  input  logic             g,
  output logic             S,
  output logic             X,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             tmo
);

  localparam int TMR_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DRIVE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] rem_reg, rem_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             early_reg, early_next;
  logic             gap_reg, gap_next;
  logic             pass_next, tmo_next;

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    timer_next = timer_reg;
    early_next = early_reg;
    gap_next   = gap_reg;
    pass_next  = pass;
    tmo_next   = tmo;
    case (state_reg)
      IDLE: begin
        if (go) begin
          state_next = START;
          rem_next   = len;
          pass_next  = 1'b0;
          tmo_next   = 1'b0;
          early_next = 1'b0;
          gap_next   = 1'b0;
        end
      end
      START: state_next = DRIVE;
      DRIVE: begin
        if (g) early_next = 1'b1;
`ifdef PULSE_GAP_EN
        if (gap_reg) begin
          gap_next = 1'b0;
        end else if (rem_reg == '0) begin
          state_next = WAIT;
          timer_next = TMR_W'(TMO - 1);
        end else begin
          rem_next = rem_reg - 1'b1;
          gap_next = 1'b1;
        end
`else
        if (rem_reg == '0) begin
          state_next = WAIT;
          timer_next = TMR_W'(TMO - 1);
        end else begin
          rem_next = rem_reg - 1'b1;
        end
`endif
      end
      WAIT: begin
        // g takes priority over an expiring timer
        if (g) begin
          state_next = DONE;
          pass_next  = ~early_reg;
          tmo_next   = 1'b0;
        end else if (timer_reg == '0) begin
          state_next = DONE;
          pass_next  = 1'b0;
          tmo_next   = 1'b1;
        end else begin
          timer_next = timer_reg - 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they align with the state they describe
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      timer_reg <= '0;
      early_reg <= 1'b0;
      gap_reg   <= 1'b0;
      S         <= 1'b0;
      X         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      tmo       <= 1'b0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      timer_reg <= timer_next;
      early_reg <= early_next;
      gap_reg   <= gap_next;
      S         <= (state_next == START);
      X         <= (state_next == DRIVE) && !gap_next;
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      pass      <= pass_next;
      tmo       <= tmo_next;
    end
  end

endmodule

// File: tb/tb_pulse_train_driver.sv
// Scoreboard bench for pulse_train_driver: expected trains are queued at go and checked at done.
// Build with PULSE_GAP_EN to exercise the gapped pulse train.
module tb_pulse_train_driver;

  localparam int CNT_W = 4;
  localparam int TMO   = 8;

  logic             clk = 1'b0;
  logic             clear;
  logic             go;
  logic [CNT_W-1:0] len;
  logic             g;
  logic             S, X, busy, done, pass, tmo;

  pulse_train_driver #(.CNT_W(CNT_W), .TMO(TMO)) dut (
    .clk(clk), .clear(clear), .go(go), .len(len), .g(g),
    .S(S), .X(X), .busy(busy), .done(done), .pass(pass), .tmo(tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pat;
    int          lat;
    logic        pass;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   abort_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Monitor: reconstructs each train from S to done and checks it against the scoreboard
  logic [63:0] x_bits = '0;
  int          x_idx = 0, last_x = 0, s_cnt = 0, s_total = 0, abort_seen = 0;
  bit          in_train = 0, post_done = 0;
  logic        held_pass = 0, held_tmo = 0;

  always @(negedge clk) begin
    exp_t e;
    if (abort_seen != abort_cnt) begin
      abort_seen = abort_cnt;
      in_train   = 0;
      s_cnt      = 0;
      post_done  = 0;
    end
    if (post_done) begin
      check("busy_fall", busy, 1'b0);
      check("pass_held", pass, held_pass);
      check("tmo_held", tmo, held_tmo);
      post_done = 0;
    end
    if (S) begin
      s_total++;
      s_cnt++;
      in_train = 1;
      x_idx    = 0;
      x_bits   = '0;
      last_x   = cyc;
      check("busy_at_s", busy, 1'b1);
    end else if (in_train && !done) begin
      if (x_idx < 64) x_bits[x_idx] = X;
      x_idx++;
      if (X) last_x = cyc;
    end
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        check("x_pattern", x_bits, e.pat);
        check("done_latency", 64'(cyc - last_x), 64'(e.lat));
        check("pass", pass, e.pass);
        check("tmo", tmo, e.tmo);
        check("one_s_per_req", 64'(s_cnt), 64'd1);
        $display("txn done: pattern=%0h latency=%0d pass=%0b tmo=%0b", x_bits, cyc - last_x, pass, tmo);
      end
      in_train  = 0;
      s_cnt     = 0;
      post_done = 1;
      held_pass = pass;
      held_tmo  = tmo;
    end
  end

  // mode 0: g never; mode 1: g in WAIT cycle arg; mode 2: g in X pulse arg and WAIT cycle 1
  task automatic run_txn(input int l, input int mode, input int arg, input bit regos);
    exp_t e;
    int   xs, wi, n;
    bit   got;
    n = l + 1;
    e.pat = '0;
    for (int i = 0; i < n; i++) begin
`ifdef PULSE_GAP_EN
      e.pat[2*i] = 1'b1;
`else
      e.pat[i] = 1'b1;
`endif
    end
    e.lat  = (mode == 0) ? TMO + 1 : ((mode == 2) ? 2 : arg + 1);
    e.pass = (mode == 1);
    e.tmo  = (mode == 0);
    @(negedge clk);
    len = CNT_W'(l);
    go  = 1'b1;
    sb.push_back(e);
    n_acc++;
    @(negedge clk);
    go = 1'b0;
    check("s_after_go", S, 1'b1);
    check("busy_after_go", busy, 1'b1);
    xs = 0; wi = 0; got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      g  = 1'b0;
      go = 1'b0;
      if (done) begin
        got = 1;
      end else begin
        if (X) xs++;
        else if (xs == n) wi++;
        if (mode == 2 && X && xs == arg) g = 1'b1;
        if (mode == 2 && wi == 1) g = 1'b1;
        if (mode == 1 && wi == arg) g = 1'b1;
        if (regos && xs >= 1) go = 1'b1;
      end
    end
    g  = 1'b0;
    go = 1'b0;
    if (!got) check("done_timeout", 1'b0, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_abort();
    int xs;
    @(negedge clk);
    len = CNT_W'(9);
    go  = 1'b1;
    n_acc++;
    @(negedge clk);
    go = 1'b0;
    xs = 0;
    for (int c = 0; c < 20 && xs < 2; c++) begin
      @(negedge clk);
      if (X) xs++;
    end
    check("abort_reached_x2", 64'(xs), 64'd2);
    #2 clear = 1'b0;
    #1;
    check("abort_x_low", X, 1'b0);
    check("abort_busy_low", busy, 1'b0);
    check("abort_done_low", done, 1'b0);
    #1 clear = 1'b1;
    abort_cnt++;
    repeat (25) @(negedge clk);
    check("abort_no_done", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    clear = 1'b0;
    go    = 1'b0;
    g     = 1'b0;
    len   = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {S, X, busy, done, pass, tmo}, 6'b0);
    clear = 1'b1;
    @(negedge clk);
`ifdef PULSE_GAP_EN
    run_txn(2, 1, 1, 0);
    run_txn(0, 1, 1, 0);
    run_txn(3, 0, 0, 0);
    run_txn(4, 2, 2, 0);
`else
    run_txn(14, 1, 1, 0);
    run_txn(3, 0, 0, 0);
    run_txn(5, 2, 3, 0);
    run_abort();
    run_txn(1, 1, 1, 0);
    run_txn(2, 1, 4, 1);
    run_txn(15, 1, TMO, 0);
    run_txn(0, 1, 1, 0);
`endif
    check("s_total", 64'(s_total), 64'(n_acc));
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
